// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode, operand read, busy scoreboard and single-entry issue register.
// Optional same-cycle writeback forwarding is selected by defining WB_BYPASS_EN.
module decode_issue (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_opc,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [31:0] out_st_data,
    output logic [4:0]  out_rd,
    output logic        out_wr,
    output logic        out_illegal,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data
);
    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_LOAD  = 6'd4;
    localparam logic [5:0] OP_MOVEI = 6'd16;
    localparam logic [5:0] OP_SLI   = 6'd17;
    localparam logic [5:0] OP_SRI   = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SUBI  = 6'd20;
    localparam logic [5:0] OP_JUMP  = 6'd21;
    localparam logic [5:0] OP_BRA   = 6'd22;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [5:0]  opc_q, opc_d;
    logic [31:0] a_q, a_d, b_q, b_d, st_q, st_d;
    logic [4:0]  rd_q, rd_d;
    logic        wr_q, wr_d, ill_q, ill_d;

    logic [5:0]  opc;
    logic [4:0]  rd, ra, rb;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic        wb_hit_rd, wb_hit_ra, wb_hit_rb;
    logic [31:0] rd_val, ra_val, rb_val;
    logic        haz_rd, haz_ra, haz_rb, dst_haz;
    logic        use_rd, use_ra, use_rb;
    logic        dec_wr, dec_ill, hazard, accept;
    logic [5:0]  dec_opc;
    logic [31:0] dec_a, dec_b, dec_st;

    assign opc      = in_instr[31:26];
    assign rd       = in_instr[25:21];
    assign ra       = in_instr[20:16];
    assign rb       = in_instr[15:11];
    assign imm      = in_instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};

    assign wb_hit_rd = wb_en && (wb_addr == rd) && (rd != 5'd0);
    assign wb_hit_ra = wb_en && (wb_addr == ra) && (ra != 5'd0);
    assign wb_hit_rb = wb_en && (wb_addr == rb) && (rb != 5'd0);

`ifdef WB_BYPASS_EN
    // A register being written back this cycle is forwarded and no longer counts as busy.
    assign rd_val  = wb_hit_rd ? wb_data : regs_q[rd];
    assign ra_val  = wb_hit_ra ? wb_data : regs_q[ra];
    assign rb_val  = wb_hit_rb ? wb_data : regs_q[rb];
    assign haz_rd  = busy_q[rd] && !wb_hit_rd;
    assign haz_ra  = busy_q[ra] && !wb_hit_ra;
    assign haz_rb  = busy_q[rb] && !wb_hit_rb;
    assign dst_haz = busy_q[rd];
`else
    // Without forwarding, a source being written this cycle stalls one cycle and reads the file next.
    assign rd_val  = regs_q[rd];
    assign ra_val  = regs_q[ra];
    assign rb_val  = regs_q[rb];
    assign haz_rd  = busy_q[rd] || wb_hit_rd;
    assign haz_ra  = busy_q[ra] || wb_hit_ra;
    assign haz_rb  = busy_q[rb] || wb_hit_rb;
    assign dst_haz = haz_rd;
`endif

    always_comb begin
        dec_opc = opc;
        dec_a   = '0;
        dec_b   = '0;
        dec_st  = '0;
        dec_ill = 1'b0;
        use_rd  = 1'b0;
        use_ra  = 1'b0;
        use_rb  = 1'b0;
        case (opc)
            6'd1, 6'd2, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11,
            6'd12, 6'd13, 6'd14, 6'd15, 6'd23, 6'd24: begin
                use_ra = 1'b1;
                use_rb = 1'b1;
                dec_a  = ra_val;
                dec_b  = rb_val;
            end
            OP_ADDI, OP_SUBI, OP_LOAD, OP_JUMP, OP_BRA: begin
                use_ra = 1'b1;
                dec_a  = ra_val;
                dec_b  = imm_sext;
            end
            OP_SLI, OP_SRI: begin
                use_ra = 1'b1;
                dec_a  = ra_val;
                dec_b  = {27'd0, imm[4:0]};
            end
            OP_MOVEI: dec_a = imm_sext;
            OP_STORE: begin
                use_rd = 1'b1;
                use_ra = 1'b1;
                dec_a  = rd_val;
                dec_b  = imm_sext;
                dec_st = ra_val;
            end
            OP_NOP: ;
            default: begin
                dec_opc = OP_NOP;
                dec_ill = 1'b1;
            end
        endcase
        dec_wr = !dec_ill && (rd != 5'd0) && (opc != OP_NOP) && (opc != OP_STORE)
                 && (opc != OP_JUMP) && (opc != OP_BRA);
    end

    assign hazard   = in_valid && ((use_rd && haz_rd) || (use_ra && haz_ra) ||
                                   (use_rb && haz_rb) || (dec_wr && dst_haz));
    assign in_ready = reset_n && (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_addr != 5'd0)) regs_d[wb_addr] = wb_data;
        // Clear first so a same-address accept in this cycle leaves the bit set.
        busy_d = busy_q;
        if (wb_en) busy_d[wb_addr] = 1'b0;
        if (accept && dec_wr) busy_d[rd] = 1'b1;

        valid_d = valid_q;
        opc_d   = opc_q;
        a_d     = a_q;
        b_d     = b_q;
        st_d    = st_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ill_d   = ill_q;
        if (accept) begin
            valid_d = 1'b1;
            opc_d   = dec_opc;
            a_d     = dec_a;
            b_d     = dec_b;
            st_d    = dec_st;
            rd_d    = rd;
            wr_d    = dec_wr;
            ill_d   = dec_ill;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            busy_q  <= '0;
            valid_q <= 1'b0;
            opc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            st_q    <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            st_q    <= st_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_opc     = opc_q;
    assign out_a       = a_q;
    assign out_b       = b_q;
    assign out_st_data = st_q;
    assign out_rd      = rd_q;
    assign out_wr      = wr_q;
    assign out_illegal = valid_q && ill_q;
endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed and random checks of decode_issue against a reference model.
module tb_decode_issue;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opc;
    logic [31:0] out_a, out_b, out_st_data;
    logic [4:0]  out_rd;
    logic        out_wr, out_illegal;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    decode_issue dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_opc(out_opc),
        .out_a(out_a), .out_b(out_b), .out_st_data(out_st_data), .out_rd(out_rd),
        .out_wr(out_wr), .out_illegal(out_illegal), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data)
    );

    always #5 clock = ~clock;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit          v;
        logic [5:0]  opc;
        logic [31:0] a, b, st;
        logic [4:0]  rd;
        bit          wr, ill;
    } slot_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    slot_t       m_slot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mk(input int opc, input int rd, input int ra, input int imm);
        return {opc[5:0], rd[4:0], ra[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] val(input int r);
        if (r == 0) return 32'd0;
        if (BYP && wb_en && (int'(wb_addr) == r)) return wb_data;
        return m_reg[r];
    endfunction

    function automatic bit hz(input int r);
        bit wbm;
        if (r <= 0) return 1'b0;
        wbm = wb_en && (int'(wb_addr) == r);
        return BYP ? (m_busy[r] && !wbm) : (m_busy[r] || wbm);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_slot = '{default: '0};
    endtask

    task automatic model_eval(output slot_t e, output bit ready);
        int opc, rd, ra, rb, s0, s1;
        logic [15:0] imm;
        bit haz;
        opc = int'(in_instr[31:26]);
        rd  = int'(in_instr[25:21]);
        ra  = int'(in_instr[20:16]);
        rb  = int'(in_instr[15:11]);
        imm = in_instr[15:0];
        e = '{default: '0};
        s0 = -1;
        s1 = -1;
        e.rd = rd[4:0];
        if (opc > 24) e.ill = 1'b1;
        else begin
            e.opc = opc[5:0];
            if (opc inside {1, 2, [5:15], 23, 24}) begin
                s0 = ra; s1 = rb; e.a = val(ra); e.b = val(rb);
            end else if (opc inside {4, 19, 20, 21, 22}) begin
                s0 = ra; e.a = val(ra); e.b = sx(imm);
            end else if (opc inside {17, 18}) begin
                s0 = ra; e.a = val(ra); e.b = {27'd0, imm[4:0]};
            end else if (opc == 16) begin
                e.a = sx(imm);
            end else if (opc == 3) begin
                s0 = rd; s1 = ra; e.a = val(rd); e.b = sx(imm); e.st = val(ra);
            end
            e.wr = !(opc inside {0, 3, 21, 22}) && (rd != 0);
        end
        haz = hz(s0) || hz(s1) || (e.wr && (BYP ? m_busy[rd] : hz(rd)));
        ready = reset_n && (!m_slot.v || out_ready) && !(in_valid && haz);
    endtask

    task automatic check_out();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_slot.v});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_slot.v && m_slot.ill});
        if (m_slot.v) begin
            chk("out_opc", {26'd0, out_opc}, {26'd0, m_slot.opc});
            chk("out_a", out_a, m_slot.a);
            chk("out_b", out_b, m_slot.b);
            chk("out_st_data", out_st_data, m_slot.st);
            chk("out_rd", {27'd0, out_rd}, {27'd0, m_slot.rd});
            chk("out_wr", {31'd0, out_wr}, {31'd0, m_slot.wr});
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        slot_t e;
        bit r;
        model_eval(e, r);
        #1 chk("in_ready", {31'd0, in_ready}, {31'd0, r});
        @(posedge clock);
        if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
        if (wb_en) m_busy[wb_addr] = 1'b0;
        if (in_valid && r) begin
            if (e.wr) m_busy[e.rd] = 1'b1;
            m_slot = e;
            m_slot.v = 1'b1;
        end else if (out_ready) m_slot.v = 1'b0;
        @(negedge clock);
        check_out();
    endtask

    task automatic drv(input bit iv, input logic [31:0] ins, input bit ordy,
                       input bit we, input int wa, input logic [31:0] wd);
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        wb_en     = we;
        wb_addr   = wa[4:0];
        wb_data   = wd;
    endtask

    initial begin
        reset_n = 1'b0;
        model_reset();
        drv(1, mk(1, 1, 3, 4 << 11), 1, 0, 0, 0);
        repeat (2) @(negedge clock);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_opc", {26'd0, out_opc}, 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_out_st", out_st_data, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_wr", {31'd0, out_wr}, 32'd0);
        chk("rst_out_ill", {31'd0, out_illegal}, 32'd0);

        // First accept at the first edge after release, alongside the R3 writeback.
        reset_n = 1'b1;
        drv(1, mk(16, 0, 0, 16'h1234), 1, 1, 3, 32'd5);
        step();
        chk("first_accept", {31'd0, out_valid}, 32'd1);
        chk("first_a", out_a, 32'h1234);
        drv(0, 0, 1, 1, 4, 32'd7);
        step();
        drv(1, mk(1, 1, 3, 4 << 11), 1, 0, 0, 0);
        step();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_opc", {26'd0, out_opc}, 32'd1);
        chk("add_a", out_a, 32'd5);
        chk("add_b", out_b, 32'd7);
        chk("add_rd", {27'd0, out_rd}, 32'd1);
        chk("add_wr", {31'd0, out_wr}, 32'd1);

        drv(1, mk(19, 2, 0, 16'hFFFF), 1, 1, 1, 32'd3);
        step();
        chk("addi_b", out_b, 32'hFFFF_FFFF);
        drv(1, mk(2, 3, 2, 1 << 11), 1, 0, 0, 0);
        step();
        step();
        #1 chk("sub_stall_ready", {31'd0, in_ready}, 32'd0);
        drv(1, mk(2, 3, 2, 1 << 11), 1, 1, 2, 32'hA);
        step();
`ifndef WB_BYPASS_EN
        drv(1, mk(2, 3, 2, 1 << 11), 1, 0, 0, 0);
        step();
`endif
        chk("sub_opc", {26'd0, out_opc}, 32'd2);
        chk("sub_a", out_a, 32'hA);

        drv(1, mk(16, 8, 0, 16'h11), 1, 0, 0, 0);
        step();
        chk("back2back_a", out_a, 32'h11);
        drv(1, mk(16, 9, 0, 16'h22), 0, 0, 0, 0);
        repeat (3) step();
        chk("held_a", out_a, 32'h11);
        #1 chk("held_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("nobubble_valid", {31'd0, out_valid}, 32'd1);
        chk("nobubble_a", out_a, 32'h22);

        drv(1, mk(40, 12, 1, 0), 1, 1, 5, 32'h100);
        step();
        chk("ill_opc", {26'd0, out_opc}, 32'd0);
        chk("ill_flag", {31'd0, out_illegal}, 32'd1);
        chk("ill_wr", {31'd0, out_wr}, 32'd0);
        drv(0, 0, 1, 1, 6, 32'd9);
        step();
        drv(1, mk(3, 5, 6, 8), 1, 0, 0, 0);
        step();
        chk("store_a", out_a, 32'h100);
        chk("store_b", out_b, 32'd8);
        chk("store_st", out_st_data, 32'd9);
        chk("store_wr", {31'd0, out_wr}, 32'd0);

        drv(1, mk(16, 7, 0, 1), 1, 0, 0, 0);
        step();
        drv(1, mk(5, 10, 7, 0), 1, 1, 7, 32'h55);
        step();
`ifdef WB_BYPASS_EN
        chk("move_fwd_opc", {26'd0, out_opc}, 32'd5);
`else
        chk("move_stall_valid", {31'd0, out_valid}, 32'd0);
        drv(1, mk(5, 10, 7, 0), 1, 0, 0, 0);
        step();
`endif
        chk("move_a", out_a, 32'h55);

        drv(1, mk(16, 7, 0, 2), 1, 0, 0, 0);
        step();
        drv(1, mk(5, 11, 7, 0), 0, 0, 0, 0);
        step();
        #2 reset_n = 1'b0;
        #1 chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        drv(1, mk(5, 11, 7, 0), 1, 0, 0, 0);
        #1 chk("postrst_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("postrst_a", out_a, 32'd0);

        for (int i = 0; i < 400; i++) begin
            drv($urandom_range(0, 3) != 0,
                mk($urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7),
                   int'($urandom & 32'h0000_BFFF)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), $urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 The block SHALL have no parameters; register count is fixed at 32 and data width at 32.
REQ-002 The block SHALL have exactly these ports, in this order:
- clock  in  1  sole clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction word present
- in_instr  in  32  opc[31:26], rd[25:21], ra[20:16], rb[15:11], imm[15:0]
- in_ready  out  1  instruction accepted this cycle when high with in_valid
- out_valid  out  1  issue register holds an instruction for the ALU
- out_ready  in  1  ALU stage takes the issue register this cycle
- out_opc  out  6  opcode to ALU OPC input
- out_a  out  32  operand to ALU RS1
- out_b  out  32  operand to ALU RS2
- out_st_data  out  32  STORE data
- out_rd  out  5  destination register
- out_wr  out  1  instruction writes out_rd
- out_illegal  out  1  undefined opcode replaced by NOP
- wb_en  in  1  register-file write strobe
- wb_addr  in  5  write address
- wb_data  in  32  write data

Function
REQ-003 Opcodes SHALL be NOP=0, ADD=1, SUB=2, STORE=3, LOAD=4, MOVE=5, SGE=6, SLE=7, SGT=8, SLT=9, SEQ=10, SNE=11, AND=12, OR=13, XOR=14, NOT=15, MOVEI=16, SLI=17, SRI=18, ADDI=19, SUBI=20, JUMP=21, BRA=22, ADDF=23, MULF=24.
REQ-004 Operands SHALL be:
- R-type (1,2,5-15,23,24): A=R[ra], B=R[rb].
- ADDI, SUBI, LOAD: A=R[ra], B=sext(imm).
- SLI, SRI: A=R[ra], B=zext(imm[4:0]).
- MOVEI: A=sext(imm), B=0.
- STORE: A=R[rd], B=sext(imm), st_data=R[ra].
- JUMP, BRA: A=R[ra], B=sext(imm).
- NOP: A=B=0.
- In all cases st_data=0 unless STORE.
REQ-005 Opcodes 25-63 SHALL issue as NOP with out_illegal=1, out_wr=0.
REQ-006 out_wr SHALL be 1 for every defined opcode except NOP, STORE, JUMP, BRA, and 0 when rd=0.
REQ-007 R0 SHALL read as 0; writes to R0 SHALL be ignored; R0 SHALL never be busy.
REQ-008 wb_en SHALL write wb_data to R[wb_addr] at the clock edge regardless of busy state.
REQ-009 A scoreboard SHALL hold one busy bit per register:
- set when an instruction with out_wr=1 is accepted into the issue register;
- cleared by wb_en to that address;
- set wins on the same-address same-cycle collision.
REQ-010 Hazard SHALL be asserted when in_valid is high and any of the following is busy or matched as in REQ-023: a read source (per REQ-004, ignoring R0 and unused fields) or the destination of a writing instruction (WAW).
REQ-011 in_ready SHALL equal (!out_valid | out_ready) & !hazard; in_ready is combinational.
REQ-012 On accept, decoded fields SHALL load into the issue register at the same edge; latency is 1 cycle to out_valid.
REQ-013 The issue register SHALL hold stable while out_valid & !out_ready.
REQ-014 out_valid SHALL clear at the edge where out_ready is high and no new accept occurs.
REQ-015 Simultaneous drain and accept SHALL replace contents with no bubble.
REQ-016 out_illegal SHALL be valid only while out_valid is high and SHALL be 0 otherwise.

Reset
REQ-017 reset_n low SHALL asynchronously clear out_valid, out_opc, out_a, out_b, out_st_data, out_rd, out_wr, out_illegal, all 32 registers and all busy bits.
REQ-018 Reset asserted mid-stall or mid-handshake SHALL discard the held instruction; no instruction reaches out_valid until after reset_n is released.
REQ-019 in_ready SHALL be 0 while reset_n is low.
REQ-020 The first accept SHALL be possible at the first rising edge after reset_n is released.

Configuration
REQ-021 Macro WB_BYPASS_EN SHALL select same-cycle writeback forwarding.
REQ-022 With WB_BYPASS_EN defined: a source equal to a nonzero wb_addr with wb_en high SHALL take wb_data and SHALL NOT count as busy for that register.
REQ-023 Without WB_BYPASS_EN: a source equal to a nonzero wb_addr with wb_en high SHALL raise hazard for that cycle; the value is read the next cycle.

Verification
REQ-024 Reset then wb R3=5, R4=7; issue ADD rd=1 ra=3 rb=4 -> next cycle out_valid=1, opc=1, a=5, b=7, rd=1, wr=1.
REQ-025 Issue ADDI rd=2 ra=0 imm=0xFFFF, then SUB ra=2 -> SUB held with in_ready=0 until wb_addr=2; out_b of ADDI=0xFFFFFFFF.
REQ-026 Hold out_ready=0 with two valid instructions -> first stays stable, in_ready=0; raise out_ready -> second issues next cycle with no bubble.
REQ-027 Instruction opc=40 -> out_opc=0, out_illegal=1, out_wr=0; STORE rd=5 ra=6 imm=8 with R5=0x100, R6=9 -> a=0x100, b=8, st_data=9, wr=0.
REQ-028 R7 busy, wb_en to R7=0x55 same cycle as MOVE ra=7 -> with WB_BYPASS_EN: accepted, a=0x55; without: 1-cycle stall, then a=0x55. Assert reset_n low mid-stall -> out_valid=0, busy cleared.
